// File: rtl/lab3_dg_keyscan.sv
`default_nettype none
// ============================================================================
//  Module   : lab3_dg_keyscan
//  Purpose  : 4x4 matrix keypad scanner. Columns are driven one-hot-low and
//             the pulled-up rows are sampled. One debounced key code is
//             emitted per press, for the 7-segment display controller.
//  Options  : define KEYSCAN_AUTOREPEAT_EN to re-pulse key_valid while a
//             key is held (REPEAT_DELAY first, then every REPEAT_PERIOD).
//  Revision : 1.0  initial release
// ============================================================================
module lab3_dg_keyscan #(
  parameter int unsigned SCAN_DIV        = 32'd2000,
  parameter int unsigned DEBOUNCE_CYCLES = 32'd50000,
  parameter int unsigned REPEAT_DELAY    = 32'd500000,
  parameter int unsigned REPEAT_PERIOD   = 32'd100000
) (
  input  logic       int_osc,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [7:0] keypress,
  output logic       key_valid,
  output logic       key_held
);

  // --------------------------------------------------------------------------
  // Counter sizing: one width shared by every counter, large enough for the
  // biggest terminal count. Counters only ever count up to (N-1).
  // --------------------------------------------------------------------------
  localparam int unsigned c_MAX_A = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned c_MAX_B = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned c_MAX   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int unsigned c_CW    = $clog2(c_MAX);

  localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);
  localparam logic [c_CW-1:0] c_SCAN_LAST = c_CW'(SCAN_DIV - 1);
  localparam logic [c_CW-1:0] c_DEB_LAST  = c_CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEYSCAN_AUTOREPEAT_EN
  localparam logic [c_CW-1:0] c_DLY_LAST  = c_CW'(REPEAT_DELAY - 1);
  localparam logic [c_CW-1:0] c_PER_LAST  = c_CW'(REPEAT_PERIOD - 1);
`endif

  // FSM encoding
  localparam logic [1:0] c_ST_SCAN     = 2'd0;
  localparam logic [1:0] c_ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] c_ST_HELD     = 2'd2;
  localparam logic [1:0] c_ST_RELEASE  = 2'd3;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [1:0]      r_state;
  logic [3:0]      r_cols;
  logic [c_CW-1:0] r_dwell;
  logic [c_CW-1:0] r_cnt;
  logic [3:0]      r_lat_row;
  logic [7:0]      r_keypress;
  logic            r_key_valid;
  logic            r_key_held;
`ifdef KEYSCAN_AUTOREPEAT_EN
  logic [c_CW-1:0] r_rpt;
  logic            r_rpt_on;
`endif

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic [3:0] w_rs;
  logic [3:0] w_low;
  logic       w_one_zero;
  logic       w_all_high;
  logic [3:0] w_next_cols;

  // Decode the synchronized rows and the next column in the rotation
  always_comb begin
    w_rs        = r_sync2;
    w_low       = ~w_rs;
    // Exactly one row pulled low: non-zero and a power of two.
    w_one_zero  = (w_low != 4'h0) && ((w_low & (w_low - 4'd1)) == 4'h0);
    w_all_high  = (w_rs == 4'hF);
    // col0 -> col1 -> col2 -> col3 -> col0 with the zero walking upward
    w_next_cols = {r_cols[2:0], r_cols[3]};
  end

  // Two-flop synchronizer; rows idle high through the pull-ups
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= rows;
      r_sync2 <= r_sync1;
    end
  end

  // Scan / debounce / hold / release state machine and output registers
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      r_state     <= c_ST_SCAN;
      r_cols      <= 4'b1110;
      r_dwell     <= '0;
      r_cnt       <= '0;
      r_lat_row   <= 4'hF;
      r_keypress  <= 8'hFF;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
`ifdef KEYSCAN_AUTOREPEAT_EN
      r_rpt       <= '0;
      r_rpt_on    <= 1'b0;
`endif
    end else begin
      // key_valid is a strobe; only the branches below raise it for a cycle
      r_key_valid <= 1'b0;
      case (r_state)
        c_ST_SCAN: begin
          if (r_dwell == c_SCAN_LAST) begin
            r_dwell <= '0;
            if (w_one_zero) begin
              // Single key in this column: freeze the column and debounce it
              r_lat_row <= w_rs;
              r_cnt     <= '0;
              r_state   <= c_ST_DEBOUNCE;
            end else begin
              // Idle column or ghost/multi-key pattern: move on
              r_cols <= w_next_cols;
            end
          end else begin
            r_dwell <= r_dwell + c_ONE;
          end
        end

        c_ST_DEBOUNCE: begin
          if (w_rs != r_lat_row) begin
            // Bounce: abandon this candidate and resume at the next column
            r_cnt   <= '0;
            r_dwell <= '0;
            r_cols  <= w_next_cols;
            r_state <= c_ST_SCAN;
          end else if (r_cnt == c_DEB_LAST) begin
            r_cnt       <= '0;
            r_keypress  <= {r_lat_row, r_cols};
            r_key_valid <= 1'b1;
            r_key_held  <= 1'b1;
            r_state     <= c_ST_HELD;
`ifdef KEYSCAN_AUTOREPEAT_EN
            r_rpt       <= '0;
            r_rpt_on    <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end

        c_ST_HELD: begin
          if (w_all_high) begin
            r_cnt   <= '0;
            r_state <= c_ST_RELEASE;
          end else begin
            // Any non-idle pattern still counts as the same key being held
`ifdef KEYSCAN_AUTOREPEAT_EN
            if (r_rpt == (r_rpt_on ? c_PER_LAST : c_DLY_LAST)) begin
              r_key_valid <= 1'b1;
              r_rpt       <= '0;
              r_rpt_on    <= 1'b1;
            end else if (r_rpt != {c_CW{1'b1}}) begin
              r_rpt <= r_rpt + c_ONE;
            end
`endif
          end
        end

        c_ST_RELEASE: begin
          if (!w_all_high) begin
            // Release bounce: the key is still down, no new strobe
            r_cnt   <= '0;
            r_state <= c_ST_HELD;
`ifdef KEYSCAN_AUTOREPEAT_EN
            r_rpt    <= '0;
            r_rpt_on <= 1'b0;
`endif
          end else if (r_cnt == c_DEB_LAST) begin
            // keypress keeps the last code until the next debounced press
            r_cnt      <= '0;
            r_key_held <= 1'b0;
            r_dwell    <= '0;
            r_cols     <= w_next_cols;
            r_state    <= c_ST_SCAN;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end

        default: begin
          r_state <= c_ST_SCAN;
        end
      endcase
    end
  end

  assign cols      = r_cols;
  assign keypress  = r_keypress;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_lab3_dg_keyscan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lab3_dg_keyscan
//  Purpose  : Directed self-checking bench for lab3_dg_keyscan with a
//             behavioural keypad model (one key, row pattern, column).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lab3_dg_keyscan;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 8;
  localparam int unsigned RDLY     = 40;
  localparam int unsigned RPER     = 16;

  logic       int_osc = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [7:0] keypress;
  logic       key_valid;
  logic       key_held;

  // keypad model: while key_on, the pattern key_rows appears when column key_col is driven
  logic       key_on;
  logic [3:0] key_rows;
  logic [1:0] key_col;

  int   checks = 0;
  int   errors = 0;
  int   kv_count = 0;
  logic kv_prev = 1'b0;
  logic kv_b2b = 1'b0;

  lab3_dg_keyscan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
  ) u_dut (
    .int_osc  (int_osc),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .keypress (keypress),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 int_osc = ~int_osc;

  // keypad contact model
  always_comb begin
    rows = 4'hF;
    if (key_on && (cols[key_col] == 1'b0)) rows = key_rows;
  end

  // strobe counter and back-to-back detector, sampled mid-cycle
  always @(negedge int_osc) begin
    if (key_valid === 1'b1) kv_count <= kv_count + 1;
    if (key_valid === 1'b1 && kv_prev === 1'b1) kv_b2b <= 1'b1;
    kv_prev <= key_valid;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance n clocks, land 2 time units after the active edge
  task automatic go(input int n);
    repeat (n) @(posedge int_osc);
    #2;
  endtask

  task automatic wait_kv(input int lim, output bit found);
    found = 1'b0;
    for (int i = 0; i < lim && !found; i++) begin
      go(1);
      if (key_valid === 1'b1) found = 1'b1;
    end
  endtask

  initial begin
    bit         found;
    logic [3:0] exp_cols;
    logic [3:0] c0;
    int         k0;

    reset    = 1'b0;
    key_on   = 1'b0;
    key_rows = 4'hF;
    key_col  = 2'd0;
    go(3);

    // reset state
    chk("rst_cols", {4'h0, cols}, 8'h0E);
    chk("rst_keypress", keypress, 8'hFF);
    chk("rst_valid", {7'd0, key_valid}, 8'h00);
    chk("rst_held", {7'd0, key_held}, 8'h00);

    // 1: idle scan rotation, 4 clocks per column (cycle 0 after release)
    reset    = 1'b1;
    exp_cols = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      chk("t1_cols", {4'h0, cols}, {4'h0, exp_cols});
      exp_cols = {exp_cols[2:0], exp_cols[3]};
      go(4);
    end
    chk("t1_no_valid", kv_count[7:0], 8'd0);
    chk("t1_keypress", keypress, 8'hFF);

    // 2: row1/col0 held
    key_rows = 4'b1101; key_col = 2'd0; key_on = 1'b1;
    wait_kv(60, found);
    chk("t2_found", {7'd0, found}, 8'h01);
    chk("t2_keypress", keypress, 8'b1101_1110);
    go(20);
    chk("t2_count", kv_count[7:0], 8'd1);
    chk("t2_held", {7'd0, key_held}, 8'h01);
    chk("t2_cols_frozen", {4'h0, cols}, 8'h0E);
    key_on = 1'b0;
    go(30);
    chk("t2_released", {7'd0, key_held}, 8'h00);
    chk("t2_keep_code", keypress, 8'b1101_1110);
    c0 = cols; go(4);
    chk("t2_rotating", {7'd0, (cols !== c0)}, 8'h01);

    // 3: chattering contact, 3 clocks down / 3 up
    for (int i = 0; i < 10; i++) begin
      key_on = ~key_on;
      go(3);
    end
    key_on = 1'b0;
    go(20);
    chk("t3_no_valid", kv_count[7:0], 8'd1);
    chk("t3_not_held", {7'd0, key_held}, 8'h00);
    c0 = cols; go(4);
    chk("t3_rotating", {7'd0, (cols !== c0)}, 8'h01);

    // 4: two rows low on col2 is ignored
    key_rows = 4'b1001; key_col = 2'd2; key_on = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (cols === 4'b1011) found = 1'b1; else go(1);
    end
    chk("t4_reach_col2", {7'd0, found}, 8'h01);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      go(1);
      if (cols !== 4'b1011) found = 1'b1;
    end
    chk("t4_next_col", {4'h0, cols}, 8'h07);
    go(30);
    chk("t4_no_valid", kv_count[7:0], 8'd1);
    chk("t4_keypress", keypress, 8'b1101_1110);
    chk("t4_not_held", {7'd0, key_held}, 8'h00);
    key_on = 1'b0;

    // 5: row3/col2 press, 4-clock release bounce, re-press
    key_rows = 4'b0111; key_col = 2'd2; key_on = 1'b1;
    wait_kv(60, found);
    chk("t5_found", {7'd0, found}, 8'h01);
    chk("t5_keypress", keypress, 8'b0111_1011);
    go(4);
    key_on = 1'b0; go(4);
    key_on = 1'b1; go(20);
    chk("t5_single", kv_count[7:0], 8'd2);
    chk("t5_held", {7'd0, key_held}, 8'h01);
    key_on = 1'b0;
    go(30);
    chk("t5_released", {7'd0, key_held}, 8'h00);
    chk("t5_keep_code", keypress, 8'b0111_1011);

    // 6a: reset during DEBOUNCE (key at col2, latched at cycle 11)
    reset = 1'b0; go(2);
    key_on = 1'b1;
    reset  = 1'b1;
    go(15);
    chk("t6_deb_cols", {4'h0, cols}, 8'h0B);
    reset = 1'b0; #1;
    chk("t6a_cols", {4'h0, cols}, 8'h0E);
    chk("t6a_keypress", keypress, 8'hFF);
    chk("t6a_held", {7'd0, key_held}, 8'h00);
    chk("t6a_valid", {7'd0, key_valid}, 8'h00);

    // 6b: exact latency 8 + 2 + 1 + 8 + 1 = cycle 20, then reset in HELD
    go(2);
    reset = 1'b1;
    go(19);
    chk("t6_lat_before", {7'd0, key_valid}, 8'h00);
    go(1);
    chk("t6_lat_pulse", {7'd0, key_valid}, 8'h01);
    chk("t6_lat_code", keypress, 8'b0111_1011);
    go(5);
    chk("t6_held_cols", {4'h0, cols}, 8'h0B);
    chk("t6_held", {7'd0, key_held}, 8'h01);
    reset = 1'b0; #1;
    chk("t6b_cols", {4'h0, cols}, 8'h0E);
    chk("t6b_keypress", keypress, 8'hFF);
    chk("t6b_held", {7'd0, key_held}, 8'h00);
    chk("t6b_valid", {7'd0, key_valid}, 8'h00);
    key_on = 1'b0;
    go(3);
    chk("t6_count", kv_count[7:0], 8'd3);
    reset = 1'b1;
    go(5);

`ifdef KEYSCAN_AUTOREPEAT_EN
    // 7: auto-repeat at press+40, then every 16
    key_rows = 4'b1101; key_col = 2'd0; key_on = 1'b1;
    wait_kv(60, found);
    chk("t7_found", {7'd0, found}, 8'h01);
    for (int k = 1; k < 100; k++) begin
      go(1);
      k0 = ((k == 40) || (k == 56) || (k == 72) || (k == 88)) ? 1 : 0;
      chk("t7_repeat", {7'd0, key_valid}, k0[7:0]);
    end
    key_on = 1'b0;
    go(30);
`else
    k0 = 0;
`endif

    chk("no_back_to_back", {7'd0, kv_b2b}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
